// File: rtl/ahb_sram_bridge_mc.sv
// ============================================================================
// Module      : ahb_sram_bridge_mc
// Description : Multi-channel AHB-to-SRAM key/data bridge with ERROR response.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ahb_sram_bridge_mc #(
    parameter int DATA_W    = 128,
    parameter int ADDR_W    = 16,
    parameter int NUM_CH    = 4,
    parameter int CH_STRIDE = 64,
    parameter int KEY_OFS   = 0,
    parameter int DATA_OFS  = 32,
    parameter int SRAM_LAT  = 1,
    localparam int c_sel_w  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               writek_enable,
    input  logic               writed_enable,
    input  logic               readd_enable,
    input  logic [c_sel_w-1:0] ch_sel,
    input  logic               hresp_error,
    input  logic               hready_enable,
    input  logic [DATA_W-1:0]  HWDATA,
    input  logic [DATA_W-1:0]  read_data,
    output logic [DATA_W-1:0]  write_data,
    output logic [DATA_W-1:0]  HRDATA,
    output logic               HREADYOUT,
    output logic               HRESP,
    output logic               read,
    output logic               write,
    output logic [ADDR_W-1:0]  addr,
    output logic               busy
);

    localparam int c_cnt_w = (SRAM_LAT > 1) ? $clog2(SRAM_LAT) : 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_READ   = 3'd2,
        ST_RD_OUT = 3'd3,
        ST_ERR1   = 3'd4,
        ST_ERR2   = 3'd5
    } state_t;

    state_t              r_state_q, w_state_d;
    logic [c_cnt_w-1:0]  r_cnt_q, w_cnt_d;
    logic [ADDR_W-1:0]   r_addr_q, w_addr_d;
    logic [DATA_W-1:0]   r_wdata_q, w_wdata_d;
    logic [DATA_W-1:0]   r_hrdata_q, w_hrdata_d;
    logic [DATA_W-1:0]   r_rdbuf_q, w_rdbuf_d;
    logic                r_ready_q, w_ready_d;
    logic                r_resp_q, w_resp_d;
    logic                r_rd_q, w_rd_d;
    logic                r_wr_q, w_wr_d;
    logic                r_busy_q, w_busy_d;

    logic                w_any_req;
    logic                w_sel_bad;
    logic                w_last;

    function automatic logic [ADDR_W-1:0] f_addr(input logic [c_sel_w-1:0] sel, input int ofs);
        return ADDR_W'(32'(sel) * 32'(CH_STRIDE) + 32'(ofs));
    endfunction

    assign w_any_req = writek_enable | writed_enable | readd_enable;
    assign w_sel_bad = (32'(ch_sel) >= 32'(NUM_CH));
    assign w_last    = (r_cnt_q == c_cnt_w'(SRAM_LAT - 1));

    always_comb begin
        w_state_d  = r_state_q;
        w_cnt_d    = r_cnt_q;
        w_addr_d   = r_addr_q;
        w_wdata_d  = r_wdata_q;
        w_hrdata_d = r_hrdata_q;
        w_rdbuf_d  = r_rdbuf_q;
        w_ready_d  = 1'b1;
        w_resp_d   = 1'b0;
        w_rd_d     = 1'b0;
        w_wr_d     = 1'b0;

        case (r_state_q)
            ST_IDLE: begin
                if (hready_enable) begin
                    w_ready_d = 1'b0;
                end else if (hresp_error || (w_any_req && w_sel_bad)) begin
                    w_state_d = ST_ERR1;
                    w_cnt_d   = '0;
                    w_ready_d = 1'b0;
                    w_resp_d  = 1'b1;
                end else if (writek_enable || writed_enable) begin
                    w_state_d = ST_WRITE;
                    w_cnt_d   = '0;
                    w_addr_d  = f_addr(ch_sel, writek_enable ? KEY_OFS : DATA_OFS);
                    w_wdata_d = HWDATA;
                    w_wr_d    = 1'b1;
                    w_ready_d = 1'b0;
                end else if (readd_enable) begin
                    w_state_d = ST_READ;
                    w_cnt_d   = '0;
                    w_addr_d  = f_addr(ch_sel, DATA_OFS);
                    w_rd_d    = 1'b1;
                    w_ready_d = 1'b0;
                end
            end
            ST_WRITE: begin
                if (w_last) begin
                    w_state_d = ST_IDLE;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d   = r_cnt_q + c_cnt_w'(1);
                    w_wr_d    = 1'b1;
                    w_ready_d = 1'b0;
                end
            end
            ST_READ: begin
                w_ready_d = 1'b0;
                if (w_last) begin
                    // Sample the SRAM while the strobe is still asserted.
                    w_rdbuf_d = read_data;
                    w_state_d = ST_RD_OUT;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d   = r_cnt_q + c_cnt_w'(1);
                    w_rd_d    = 1'b1;
                end
            end
            ST_RD_OUT: begin
                w_hrdata_d = r_rdbuf_q;
                w_state_d  = ST_IDLE;
                w_cnt_d    = '0;
            end
            ST_ERR1: begin
                w_state_d = ST_ERR2;
                w_cnt_d   = '0;
                w_resp_d  = 1'b1;
            end
            ST_ERR2: begin
                w_state_d = ST_IDLE;
                w_cnt_d   = '0;
            end
            default: begin
                w_state_d = ST_IDLE;
                w_cnt_d   = '0;
            end
        endcase

        w_busy_d = (w_state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= ST_IDLE;
            r_cnt_q    <= '0;
            r_addr_q   <= '0;
            r_wdata_q  <= '0;
            r_hrdata_q <= '0;
            r_rdbuf_q  <= '0;
            r_ready_q  <= 1'b1;
            r_resp_q   <= 1'b0;
            r_rd_q     <= 1'b0;
            r_wr_q     <= 1'b0;
            r_busy_q   <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_cnt_q    <= w_cnt_d;
            r_addr_q   <= w_addr_d;
            r_wdata_q  <= w_wdata_d;
            r_hrdata_q <= w_hrdata_d;
            r_rdbuf_q  <= w_rdbuf_d;
            r_ready_q  <= w_ready_d;
            r_resp_q   <= w_resp_d;
            r_rd_q     <= w_rd_d;
            r_wr_q     <= w_wr_d;
            r_busy_q   <= w_busy_d;
        end
    end

    assign write_data = r_wdata_q;
    assign HRDATA     = r_hrdata_q;
    assign HREADYOUT  = r_ready_q;
    assign HRESP      = r_resp_q;
    assign read       = r_rd_q;
    assign write      = r_wr_q;
    assign addr       = r_addr_q;
    assign busy       = r_busy_q;

endmodule

`default_nettype wire
